// File: rtl/io_irq_responder.sv
// Memory-mapped I/O responder: edge-latched interrupt lines, optional countdown timer, masked irq.
// Timer feature is built only when IO_RESP_TIMER_EN is defined.
module io_irq_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned WAIT    = 1,
    parameter int unsigned TIMER_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              ack,
    input  logic [3:0]        interrupts,
    output logic              irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_wcnt;
    logic [2:0]  w_wcnt_nxt;

    logic        w_access;
    logic        w_hit;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_stat;
    logic        w_wr_rel;
    logic        w_wr_cnt;
    logic [31:0] w_rd_mux;
    logic [31:0] w_ctrl_rd;
    logic [31:0] w_stat_rd;
    logic [31:0] w_reload_rd;
    logic [31:0] w_count_rd;
    logic        w_tpend;
    logic        w_tmask;

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_sync3;
    logic [3:0]  w_edge;
    logic [3:0]  r_lpend;
    logic [3:0]  r_lmask;

    logic        w_unused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT == 0) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_wcnt_nxt  = 3'(WAIT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (r_wcnt == '0) w_state_nxt = S_ACK;
                else              w_wcnt_nxt  = r_wcnt - 3'd1;
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign ack = (r_state == S_ACK);

    // The access takes effect on the edge that moves the FSM into ACK.
    assign w_access  = (r_state != S_ACK) && (w_state_nxt == S_ACK);
    assign w_hit     = (addr[ADDR_W-1:4] == '0);
    assign w_wr      = w_access & wr_en & w_hit;
    assign w_wr_ctrl = w_wr & (addr[3:2] == 2'd0);
    assign w_wr_stat = w_wr & (addr[3:2] == 2'd1);
    assign w_wr_rel  = w_wr & (addr[3:2] == 2'd2);
    assign w_wr_cnt  = w_wr & (addr[3:2] == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= interrupts;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_sync3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lmask <= '0;
            r_lpend <= '0;
            irq     <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_lmask <= wr_data[7:4];
            // OR-ing the edge in after the clear lets a same-cycle edge win.
            r_lpend <= (r_lpend & ~(w_wr_stat ? wr_data[3:0] : 4'b0000)) | w_edge;
            irq     <= |({w_tpend, r_lpend} & {w_tmask, r_lmask});
        end
    end

`ifdef IO_RESP_TIMER_EN
    logic               r_ten;
    logic               r_auto;
    logic               r_tmask;
    logic               r_tpend;
    logic [TIMER_W-1:0] r_reload;
    logic [TIMER_W-1:0] r_count;
    logic               w_tick;
    logic               w_zero;

    // A CTRL write clearing TEN halts the timer in that same cycle.
    assign w_tick = r_ten & ~(w_wr_ctrl & ~wr_data[0]);
    assign w_zero = (r_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ten    <= 1'b0;
            r_auto   <= 1'b0;
            r_tmask  <= 1'b0;
            r_tpend  <= 1'b0;
            r_reload <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ten   <= wr_data[0];
                r_auto  <= wr_data[1];
                r_tmask <= wr_data[8];
            end else if (w_tick && w_zero && !r_auto) begin
                r_ten <= 1'b0;
            end
            if (w_wr_rel) r_reload <= wr_data[TIMER_W-1:0];
            if (w_wr_cnt) begin
                r_count <= wr_data[TIMER_W-1:0];
            end else if (w_tick) begin
                if (!w_zero)    r_count <= r_count - TIMER_W'(1);
                else if (r_auto) r_count <= r_reload;
            end
            r_tpend <= (r_tpend & ~(w_wr_stat & wr_data[4])) | (w_tick & w_zero);
        end
    end

    assign w_tpend     = r_tpend;
    assign w_tmask     = r_tmask;
    assign w_ctrl_rd   = {23'b0, r_tmask, r_lmask, 2'b00, r_auto, r_ten};
    assign w_stat_rd   = {27'b0, r_tpend, r_lpend};
    assign w_reload_rd = 32'(r_reload);
    assign w_count_rd  = 32'(r_count);
`else
    logic w_unused_tmr;

    assign w_tpend      = 1'b0;
    assign w_tmask      = 1'b0;
    assign w_ctrl_rd    = {24'b0, r_lmask, 4'b0000};
    assign w_stat_rd    = {28'b0, r_lpend};
    assign w_reload_rd  = '0;
    assign w_count_rd   = '0;
    assign w_unused_tmr = w_wr_rel ^ w_wr_cnt ^ (TIMER_W == 0);
`endif

    always_comb begin
        w_rd_mux = '0;
        unique case (addr[3:2])
            2'd0:    w_rd_mux = w_ctrl_rd;
            2'd1:    w_rd_mux = w_stat_rd;
            2'd2:    w_rd_mux = w_reload_rd;
            2'd3:    w_rd_mux = w_count_rd;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (w_access) begin
            rd_data <= w_hit ? w_rd_mux : '0;
        end
    end

    assign w_unused = ^{wr_data, addr[1:0]};

endmodule

// File: tb/tb_io_irq_responder.sv
// Directed self-checking bench for io_irq_responder (WAIT=1); timer checks follow IO_RESP_TIMER_EN.
module tb_io_irq_responder;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr_en;
    logic [7:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ack;
    logic [3:0]  interrupts;
    logic        irq;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_RELOAD = 8'h08;
    localparam logic [7:0] A_COUNT  = 8'h0C;

    io_irq_responder #(
        .ADDR_W (8),
        .WAIT   (1),
        .TIMER_W(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .wr_en     (wr_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .ack       (ack),
        .interrupts(interrupts),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus transaction; returns read data and cycles from req to the ack sample.
    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] q, output int cyc);
        @(negedge clk);
        req = 1'b1; wr_en = w; addr = a; wr_data = d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ack && cyc < 20);
        q = rd_data;
        checks++;
        if (!ack) begin
            errors++;
            $display("FAIL bus_timeout addr=%h got no ack required ack within 20 cycles", a);
        end
        req = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] q;
        int c;
        bus(1'b1, a, d, q, c);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] q);
        int c;
        bus(1'b0, a, 32'h0, q, c);
    endtask

    task automatic test_reset;
        logic [31:0] q;
        int c;
        reset = 1'b1; req = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0; interrupts = '0;
        tick(3);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b required 0", ack); end
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h required 0", rd_data); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b required 0", irq); end
        reset = 1'b0;
        tick(2);
        bus(1'b0, A_CTRL, 32'h0, q, c);
        checks++;
        if (c !== 2) begin errors++; $display("FAIL read_latency got %0d required 2", c); end
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h required 0", q); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after got %b required 0", irq); end
    endtask

    task automatic test_line_irq;
        logic [31:0] q;
        wr(A_CTRL, 32'h0000_0010);
        @(negedge clk);
        interrupts[0] = 1'b1;
        tick(3);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b required 0", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_latency got %b required 1", irq); end
        interrupts[0] = 1'b0;
        rd(A_STATUS, q);
        checks++;
        if (q !== 32'h1) begin errors++; $display("FAIL status_line0 got %h required 00000001", q); end
        tick(2);
        checks++;
        if (rd_data !== 32'h1) begin errors++; $display("FAIL rd_data_hold got %h required 00000001", rd_data); end
        wr(A_STATUS, 32'h1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_w1c_ack got %b required 1", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b required 0", irq); end
        rd(A_STATUS, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL status_cleared got %h required 0", q); end
    endtask

    task automatic test_set_wins;
        logic [31:0] q;
        @(negedge clk);
        interrupts[2] = 1'b1;
        tick(2);
        interrupts[2] = 1'b0;
        tick(4);
        rd(A_STATUS, q);
        checks++;
        if (q !== 32'h4) begin errors++; $display("FAIL status_line2 got %h required 00000004", q); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL masked_line2_irq got %b required 0", irq); end
        // Edge detected on the same clock that commits the W1C.
        @(negedge clk);
        interrupts[2] = 1'b1;
        wr(A_STATUS, 32'h4);
        interrupts[2] = 1'b0;
        rd(A_STATUS, q);
        checks++;
        if (q !== 32'h4) begin errors++; $display("FAIL set_wins got %h required 00000004", q); end
        wr(A_STATUS, 32'hF);
        rd(A_STATUS, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL status_clear_all got %h required 0", q); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] q;
        int c;
        bus(1'b1, 8'h40, 32'hFFFF_FFFF, q, c);
        checks++;
        if (c !== 2) begin errors++; $display("FAIL oor_write_ack got %0d cycles required 2", c); end
        bus(1'b0, 8'h40, 32'h0, q, c);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL oor_read got %h required 0", q); end
        rd(A_CTRL, q);
        checks++;
        if (q !== 32'h10) begin errors++; $display("FAIL oor_ctrl_unchanged got %h required 00000010", q); end
        rd(A_STATUS, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL oor_status_unchanged got %h required 0", q); end
    endtask

`ifdef IO_RESP_TIMER_EN
    task automatic test_timer;
        logic [31:0] q;
        wr(A_RELOAD, 32'd3);
        wr(A_COUNT, 32'd3);
        wr(A_CTRL, 32'h103);
        tick(4);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL timer_early got %b required 0", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL timer_first got %b required 1", irq); end
        tick(1);
        wr(A_STATUS, 32'h10);
        tick(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL timer_cleared got %b required 0", irq); end
        tick(2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL timer_gap got %b required 0", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL timer_period got %b required 1", irq); end
        wr(A_CTRL, 32'h100);
        wr(A_STATUS, 32'h10);
        wr(A_COUNT, 32'd2);
        wr(A_CTRL, 32'h101);
        tick(6);
        rd(A_CTRL, q);
        checks++;
        if (q !== 32'h100) begin errors++; $display("FAIL oneshot_ten got %h required 00000100", q); end
        rd(A_STATUS, q);
        checks++;
        if (q !== 32'h10) begin errors++; $display("FAIL oneshot_pending got %h required 00000010", q); end
        wr(A_STATUS, 32'h10);
        tick(8);
        rd(A_STATUS, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL oneshot_once got %h required 0", q); end
        rd(A_COUNT, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL oneshot_count got %h required 0", q); end
    endtask
`else
    task automatic test_no_timer;
        logic [31:0] q;
        wr(A_COUNT, 32'd5);
        rd(A_COUNT, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL count_absent got %h required 0", q); end
        wr(A_RELOAD, 32'd7);
        rd(A_RELOAD, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL reload_absent got %h required 0", q); end
        wr(A_CTRL, 32'h1F3);
        rd(A_CTRL, q);
        checks++;
        if (q !== 32'hF0) begin errors++; $display("FAIL ctrl_timer_bits got %h required 000000f0", q); end
        tick(10);
        rd(A_STATUS, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL status_no_timer got %h required 0", q); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_no_timer got %b required 0", irq); end
    endtask
`endif

    task automatic test_reset_mid_access;
        logic [31:0] q;
        @(negedge clk);
        req = 1'b1; wr_en = 1'b1; addr = A_CTRL; wr_data = 32'h0000_00F1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0) begin errors++; $display("FAIL abort_ack cycle %0d got %b required 0", i, ack); end
        end
        req = 1'b0; wr_en = 1'b0;
        reset = 1'b0;
        tick(2);
        rd(A_CTRL, q);
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL abort_ctrl got %h required 0", q); end
    endtask

    initial begin
        test_reset();
        test_line_irq();
        test_set_wins();
        test_out_of_range();
`ifdef IO_RESP_TIMER_EN
        test_timer();
`else
        test_no_timer();
`endif
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_irq_responder.md
# io_irq_responder

Memory-mapped I/O responder on the processor data port, answering the same request/acknowledge protocol as the data memory with a configurable wait-state count. It latches edges on the external `interrupts` lines into a pending register, provides an optional countdown timer, and raises a single masked `irq` toward the processor. It sits beside the data memory on the data bus, selected by the top level's address decode.

## Interface
- `ADDR_W`, 8, byte-address width seen by the block.
- `WAIT`, 1, wait cycles inserted before `ack` (0..7).
- `TIMER_W`, 16, timer counter width (1..32).

- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req`  in  1  access request; `addr`, `wr_en`, `wr_data` held stable until `ack`.
- `wr_en`  in  1  1 = write, 0 = read.
- `addr`  in  ADDR_W  byte address; `addr[3:2]` selects register.
- `wr_data`  in  32  write data.
- `rd_data`  out  32  read data, registered; valid in `ack` cycle, held until next `ack`.
- `ack`  out  1  one-cycle completion pulse.
- `interrupts`  in  4  asynchronous external interrupt lines.
- `irq`  out  1  registered OR of enabled pending sources.

## Operation
- Register map:
  - 0x0 CTRL: bit0 TEN, bit1 AUTO, bits[7:4] line mask, bit8 timer mask; other bits read 0.
  - 0x4 STATUS: bits[3:0] line pending, bit4 timer pending; write-1-to-clear.
  - 0x8 RELOAD: TIMER_W bits, zero-extended on read.
  - 0xC COUNT: reads live counter; write loads it.
- `addr[ADDR_W-1:4] != 0`: read returns 0, write ignored, `ack` still issued. `addr[1:0]` ignored.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: `req`=1 -> WAIT with wait counter = WAIT-1 (or directly to ACK if WAIT=0).
  - WAIT: decrement; at 0 -> ACK.
  - ACK: `ack`=1 for one cycle -> IDLE unconditionally. `req` is sampled only in IDLE.
- Write commits and `rd_data` loads on the edge entering ACK.
- Lines: 2-flop synchronizer per line, then rising-edge detect; an edge sets `pending[i]` regardless of mask.
- Same-cycle edge set and W1C clear on one bit: set wins.
- Timer, when TEN=1, each cycle:
  - COUNT != 0: decrement.
  - COUNT == 0: set timer pending; AUTO=1 reloads COUNT from RELOAD, AUTO=0 clears TEN.
  - A COUNT write in the same cycle overrides the decrement/reload.
  - A TEN write of 0 stops the timer immediately.
  - RELOAD=0 with AUTO=1 sets pending every cycle.
- `irq` <= |({timer_pending, line_pending} & {timer mask, line mask}), registered, one cycle after the pending/mask change.

## Timing
- Reset values: `ack`=0, `rd_data`=0, `irq`=0, FSM=IDLE, all registers and synchronizer/edge flops 0.
- Request latency: `req` high in IDLE at cycle n -> `ack` high at cycle n+1+WAIT. Minimum access period is WAIT+2 cycles.
- Interrupt latency: line rises at cycle n (setup met) -> pending visible at n+3 -> `irq` at n+4 if unmasked.
- A line held high through reset release produces one pending set 3 cycles after release.
- Reset asserted mid-access aborts the access: no `ack`, no write committed.
- Reads of STATUS or COUNT return the value registered on the edge entering ACK, including same-edge updates not yet applied (pre-edge value).

## Configuration
- `IO_RESP_TIMER_EN` defined: timer, RELOAD, COUNT, and timer pending/mask are present as described.
- `IO_RESP_TIMER_EN` undefined: timer logic is removed. RELOAD/COUNT read 0 and writes are ignored. CTRL bits 0, 1, 8 and STATUS bit4 read 0, and the timer never contributes to `irq`.

## Test plan
- WAIT=1, read CTRL after reset: `req` at cycle 5 -> `ack` only at cycle 7, `rd_data`=0, `irq`=0.
- Write CTRL=0x0000_0010, pulse `interrupts[0]` -> STATUS reads 0x01, `irq`=1. Write STATUS=0x01 -> STATUS 0, `irq` falls the next cycle.
- Line edge on bit 2 landing in the same cycle as a W1C of bit 2 -> bit 2 remains 1.
- RELOAD=3, COUNT=3, CTRL=0x103 -> timer pending every 4 cycles; with AUTO=0 it fires once and TEN reads 0.
- Access to 0x40: write 0xFFFF_FFFF then read -> `ack` issued, read returns 0, registers unchanged.
- Reset asserted during WAIT of a write to CTRL=0x1 -> no `ack`, CTRL reads 0 afterward. Build without `IO_RESP_TIMER_EN`: COUNT write of 5 reads back 0.
